// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: instruction FIFO, RAW scoreboard and registered issue port.
// Optional stall/issue counters are built when ISSUE_STATS_EN is defined.
module pipe_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 3
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_rs1,
    input  logic [3:0] in_rs2,
    input  logic [3:0] in_rd,
    input  logic [3:0] in_func,
    input  logic [7:0] in_addr,
    input  logic       flush,
    output logic       iss_valid,
    output logic [3:0] iss_rs1,
    output logic [3:0] iss_rs2,
    output logic [3:0] iss_rd,
    output logic [3:0] iss_func,
    output logic [7:0] iss_addr,
    output logic       stall,
    output logic       illegal,
    output logic       busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] issue_cnt
`endif
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    instr_t            mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WB_LAT-1:0] sb_v_q;
    logic [3:0]        sb_rd_q [WB_LAT];
    instr_t            iss_q, iss_d;
    logic              iss_valid_q, iss_valid_d;
    logic              stall_q, stall_d;
    logic              illegal_q, illegal_d;

    instr_t head;
    logic   full, empty, use_a, use_b, legal, hazard;
    logic   active, push, pop, issue;

    assign head     = mem_q[rd_ptr_q];
    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;

    // Decode which operands the head func actually reads; 12-15 are illegal.
    always_comb begin
        use_a = 1'b0;
        use_b = 1'b0;
        legal = 1'b1;
        case (head.func)
            4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            4'd3, 4'd8, 4'd10, 4'd11: use_a = 1'b1;
            4'd4, 4'd9:               use_b = 1'b1;
            default:                  legal = 1'b0;
        endcase
    end

    // RAW check of the head against every in-flight destination; rd/rd is harmless in order.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_v_q[i] && ((use_a && (sb_rd_q[i] == head.rs1)) ||
                              (use_b && (sb_rd_q[i] == head.rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    // Per-cycle decision and next-state for FIFO bookkeeping and issue registers.
    always_comb begin
        active = !empty && !flush;
        // Illegal heads are dropped regardless of hazards.
        pop    = active && (!legal || !hazard);
        issue  = active && legal && !hazard;
        // No bypass when full: in_ready already reflects the pre-pop count.
        push   = in_valid && !full && !flush;

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CntW'(push) - CntW'(pop);
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
        end

        iss_valid_d = issue;
        iss_d       = issue ? head : iss_q;
        stall_d     = active && legal && hazard;
        illegal_d   = active && !legal;
    end

    // FIFO storage needs no reset; the count defines which entries are live.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func,
                                 addr: in_addr};
        end
    end

    // Control state and issue port registers.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            stall_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            stall_q     <= stall_d;
            illegal_q   <= illegal_d;
        end
    end

    // Scoreboard shift register; flush leaves in-flight entries to drain naturally.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            sb_v_q <= '0;
            for (int i = 0; i < WB_LAT; i++) sb_rd_q[i] <= '0;
        end else begin
            sb_v_q[0]  <= issue;
            sb_rd_q[0] <= head.rd;
            for (int i = 1; i < WB_LAT; i++) begin
                sb_v_q[i]  <= sb_v_q[i-1];
                sb_rd_q[i] <= sb_rd_q[i-1];
            end
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_rs1   = iss_q.rs1;
    assign iss_rs2   = iss_q.rs2;
    assign iss_rd    = iss_q.rd;
    assign iss_func  = iss_q.func;
    assign iss_addr  = iss_q.addr;
    assign stall     = stall_q;
    assign illegal   = illegal_q;
    assign busy      = !empty || (|sb_v_q);

`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt_q, issue_cnt_q;

    // Stall count saturates, issue count wraps; neither is cleared by flush.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (issue) issue_cnt_q <= issue_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: queue-based reference model compared every cycle,
// plus hand-computed literal checks for latency, stall length, full and flush behaviour.
module tb_pipe_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WB_LAT = 3;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    logic       clk1 = 1'b0;
    logic       rst_n, in_valid, in_ready, flush;
    logic [3:0] in_rs1, in_rs2, in_rd, in_func;
    logic [7:0] in_addr;
    logic       iss_valid, stall, illegal, busy;
    logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0] iss_addr;
`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt, issue_cnt;
`endif

    always #5 clk1 = ~clk1;

    pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_func   (in_func),
        .in_addr   (in_addr),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_func  (iss_func),
        .iss_addr  (iss_addr),
        .stall     (stall),
        .illegal   (illegal),
        .busy      (busy)
`ifdef ISSUE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ins_t       mq[$];
    int         hist_edge[$];
    logic [3:0] hist_rd[$];
    int         cyc = 0;
    logic       e_v, e_st, e_il;
    ins_t       e_f;
    int         m_issues, m_stalls;
    logic [15:0] a_mask = 16'h0DEF;
    logic [15:0] b_mask = 16'h02F7;

    // Observations of the DUT for literal checks
    int          obs_iss, obs_stall, obs_ill, obs_first, obs_last;
    logic [15:0] obs_rd_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_hazard(input ins_t h);
        for (int k = 0; k < hist_edge.size(); k++) begin
            if ((cyc - hist_edge[k]) < int'(WB_LAT)) begin
                if ((a_mask[h.func] && hist_rd[k] == h.rs1) ||
                    (b_mask[h.func] && hist_rd[k] == h.rs2)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit m_busy();
        if (mq.size() > 0) return 1'b1;
        for (int k = 0; k < hist_edge.size(); k++)
            if ((cyc - hist_edge[k]) < int'(WB_LAT)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void obs_clear();
        obs_iss = 0; obs_stall = 0; obs_ill = 0; obs_first = 0; obs_last = 0;
        obs_rd_mask = '0;
    endfunction

    // One clock: advance the model from current inputs, take the edge, compare everything.
    task automatic tick();
        ins_t h;
        bit   rdy;
        if (!rst_n) begin
            mq.delete(); hist_edge.delete(); hist_rd.delete();
            e_v = 0; e_st = 0; e_il = 0; e_f = '0; m_issues = 0; m_stalls = 0;
        end else begin
            rdy = (mq.size() < DEPTH);
            e_v = 0; e_st = 0; e_il = 0;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0) begin
                    h = mq[0];
                    if (h.func >= 4'd12) begin
                        void'(mq.pop_front());
                        e_il = 1;
                    end else if (m_hazard(h)) begin
                        e_st = 1;
                        m_stalls++;
                    end else begin
                        void'(mq.pop_front());
                        e_v = 1;
                        e_f = h;
                        hist_edge.push_back(cyc + 1);
                        hist_rd.push_back(h.rd);
                        m_issues++;
                    end
                end
                if (in_valid && rdy) mq.push_back('{rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                                                     func: in_func, addr: in_addr});
            end
        end
        @(posedge clk1);
        cyc++;
        #1;
        check("iss_valid", {31'd0, iss_valid}, {31'd0, e_v});
        check("iss_fields", {8'd0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, {8'd0, e_f});
        check("stall", {31'd0, stall}, {31'd0, e_st});
        check("illegal", {31'd0, illegal}, {31'd0, e_il});
        check("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < DEPTH)});
        check("busy", {31'd0, busy}, {31'd0, m_busy()});
`ifdef ISSUE_STATS_EN
        check("issue_cnt", {16'd0, issue_cnt}, m_issues);
        check("stall_cnt", {16'd0, stall_cnt}, m_stalls);
`endif
        if (iss_valid) begin
            if (obs_iss == 0) obs_first = cyc;
            obs_last = cyc;
            obs_iss++;
            obs_rd_mask[iss_rd] = 1'b1;
        end
        if (stall) obs_stall++;
        if (illegal) obs_ill++;
    endtask

    task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic [3:0] func, input logic [7:0] addr);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_func = func; in_addr = addr;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        check("drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        obs_clear();
        // 1. Reset with in_valid high
        drive(4'd1, 4'd2, 4'd3, 4'd0, 8'hAA);
        tick(); tick();
        check("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fields", {8'd0, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 32'd0);
        rst_n = 1'b1; idle();
        tick();
        check("rst_nothing_accepted", {31'd0, busy}, 32'd0);

        // 2. Independent stream
        obs_clear();
        drive(4'd1, 4'd2, 4'd3, 4'd0, 8'h10); tick();
        drive(4'd4, 4'd5, 4'd6, 4'd1, 8'h11); tick();
        check("ind_first_valid", {31'd0, iss_valid}, 32'd1);
        check("ind_first_rd", {28'd0, iss_rd}, 32'd3);
        check("ind_first_addr", {24'd0, iss_addr}, 32'h10);
        idle(); tick();
        check("ind_second_valid", {31'd0, iss_valid}, 32'd1);
        check("ind_second_rd", {28'd0, iss_rd}, 32'd6);
        drain();
        check("ind_no_stall", obs_stall, 32'd0);

        // 3. RAW hazard: consumer issues WB_LAT+1 edges after producer
        obs_clear();
        drive(4'd0, 4'd0, 4'd3, 4'd0, 8'h20); tick();
        drive(4'd3, 4'd0, 4'd8, 4'd3, 8'h21); tick();
        drain();
        check("raw_issue_count", obs_iss, 32'd2);
        check("raw_issue_gap", obs_last - obs_first, 32'd4);
        check("raw_stall_cycles", obs_stall, 32'd3);

        // 4. Unused operand does not create a hazard
        obs_clear();
        drive(4'd0, 4'd0, 4'd7, 4'd0, 8'h30); tick();
        drive(4'd7, 4'd1, 4'd9, 4'd4, 8'h31); tick();
        drain();
        check("unused_gap", obs_last - obs_first, 32'd1);
        check("unused_no_stall", obs_stall, 32'd0);

        // 5a. Illegal func dropped
        obs_clear();
        drive(4'd1, 4'd1, 4'd2, 4'd13, 8'h40); tick();
        idle(); tick(); tick();
        check("illegal_pulses", obs_ill, 32'd1);
        check("illegal_no_issue", obs_iss, 32'd0);
        drain();

        // 5b. Fill the FIFO behind a hazard; the push while full is refused
        obs_clear();
        drive(4'd0, 4'd0, 4'd9, 4'd0, 8'h50); tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(4'd9, 4'd0, 4'(10 + i), 4'd3, 8'(8'h51 + i)); tick();
        end
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(4'd0, 4'd0, 4'd15, 4'd0, 8'h5F); tick();
        drain();
        check("full_rejected", {31'd0, obs_rd_mask[15]}, 32'd0);
        check("full_issue_count", obs_iss, 32'd5);

        // 6. Flush while three instructions wait behind a hazard
        drive(4'd0, 4'd0, 4'd4, 4'd0, 8'h60); tick();
        drive(4'd4, 4'd0, 4'd5, 4'd3, 8'h61); tick();
        drive(4'd5, 4'd0, 4'd1, 4'd3, 8'h62); tick();
        drive(4'd5, 4'd0, 4'd2, 4'd3, 8'h63); tick();
        drive(4'd5, 4'd0, 4'd3, 4'd3, 8'h64); tick();
        idle(); tick();
        obs_clear();
        drive(4'd0, 4'd0, 4'd14, 4'd0, 8'h65); flush = 1'b1; tick();
        flush = 1'b0; idle();
        check("flush_busy", {31'd0, busy}, 32'd1);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_no_issue", {31'd0, iss_valid}, 32'd0);
        drain();
        check("flush_nothing_issued", obs_iss, 32'd0);

        // Reset mid-operation
        drive(4'd0, 4'd0, 4'd6, 4'd0, 8'h70); tick();
        drive(4'd6, 4'd0, 4'd7, 4'd3, 8'h71); tick();
        rst_n = 1'b0; idle(); tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1; tick();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_issue_ctrl.md
Name: pipe_issue_ctrl

Overview:
In-order issue controller for the 4-stage register-bank/ALU/memory pipeline. Buffers instructions from an upstream requester through a valid/ready handshake. Holds the head instruction while it has a read-after-write hazard against an instruction that has not yet written the register bank. Drives the pipeline's rs1/rs2/rd/func/addr inputs with a one-cycle issue strobe.

Parameters:
DEPTH, 4, instruction FIFO depth; power of 2, minimum 2.
WB_LAT, 3, cycles from issue until the result is written to the register bank; sets the scoreboard length.

Ports:
clk1  in  1  single clock; all logic on posedge.
rst_n  in  1  reset, synchronous, active-low.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  FIFO can accept an instruction.
in_rs1  in  4  source register A index.
in_rs2  in  4  source register B index.
in_rd  in  4  destination register index.
in_func  in  4  ALU function code.
in_addr  in  8  memory word address.
flush  in  1  discard all queued, unissued instructions.
iss_valid  out  1  issue strobe, registered.
iss_rs1  out  4  issued rs1.
iss_rs2  out  4  issued rs2.
iss_rd  out  4  issued rd.
iss_func  out  4  issued func.
iss_addr  out  8  issued addr.
stall  out  1  head instruction blocked by a hazard, registered.
illegal  out  1  one-cycle pulse when an illegal func is dropped.
busy  out  1  FIFO non-empty or any scoreboard slot valid.

Behaviour:
- Clocking and reset: one clock, clk1. Reset is synchronous and active-low on rst_n.
- Reset values: FIFO empty; scoreboard all invalid; iss_valid=0, stall=0, illegal=0; all iss_* fields=0; in_ready=1; busy=0.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !full, combinational from FIFO count. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- Operand use by func:
  - Operand A is used for func 0,1,2,3,5,6,7,8,10,11.
  - Operand B is used for func 0,1,2,4,5,6,7,9.
  - func 12-15 is illegal.
- Scoreboard:
  - WB_LAT slots of {v, rd}, shifting one slot per cycle.
  - Slot 0 loads {1, iss_rd} on an issue edge; otherwise it loads {0, x}.
  - The last slot is discarded on each shift.
- Hazard: the head has a hazard if any valid slot's rd equals head rs1 (when A is used) or head rs2 (when B is used). rd/rd conflicts are ignored because issue is in order.
- Per-cycle decision, evaluated on the head when the FIFO is non-empty:
  - Illegal head: pop it, no issue, illegal=1 next cycle. This takes precedence over the hazard check.
  - Legal head, no hazard: pop, issue. iss_valid=1 and iss_* = head fields next cycle.
  - Legal head, hazard: hold. stall=1 next cycle.
- Output hold: iss_* hold their last issued value whenever iss_valid=0.
- Issue rate: at most one issue per cycle.
- Latency:
  - An instruction accepted into an empty FIFO at edge E with no hazard shows iss_valid at edge E+1.
  - A dependent instruction queued behind its producer (producer issue edge P) issues at edge P+WB_LAT+1, i.e. WB_LAT stall cycles.
- FIFO: circular with a count. Pointers wrap at DEPTH. Simultaneous push and pop when not full leaves the count unchanged.
- flush: empties the FIFO and suppresses that cycle's issue and push (flush beats accept). The scoreboard is untouched, so in-flight hazards still clear naturally.
- Reset mid-operation: all state returns to reset values at the next edge. In-flight scoreboard entries are lost.

Optional Feature:
Macro ISSUE_STATS_EN.
- Defined:
  - Adds output stall_cnt[15:0], incremented on each stall cycle and saturating at 16'hFFFF.
  - Adds output issue_cnt[15:0], incremented on each issue and wrapping.
  - Both counters reset to 0 on rst_n low and are not affected by flush.
- Not defined: neither port nor any counter logic exists.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1 -> iss_valid=0, in_ready=1, busy=0; nothing accepted.
2. Independent stream: push (rs1=1,rs2=2,rd=3,func=0), then (rs1=4,rs2=5,rd=6,func=1) on consecutive cycles -> iss_valid on 2 consecutive cycles in order, stall=0.
3. RAW hazard: push rd=3 func=0, then rs1=3 func=3, WB_LAT=3 -> second issues exactly 4 edges after the first; stall high for 3 cycles.
4. Unused operand: producer rd=7, next func=4 (B only) with rs1=7, rs2=1 -> no stall, back-to-back issue.
5. Illegal and full: push func=13 -> illegal pulses once, no iss_valid. Then hold a hazard and push DEPTH more -> in_ready=0 at count 4; a push attempt while full is not accepted.
6. Flush: 3 queued behind a hazard, assert flush with in_valid=1 -> FIFO empty next cycle, flush-cycle instruction dropped, no issue; busy stays 1 until the scoreboard drains.
